// File: rtl/lfsr_engine_param_if.sv
// Request/result bundle between a host and lfsr_engine_param.
// Host drives go/seed_val/seed/nshift/done_rdy; engine drives busy/done_val/rand_out.
interface lfsr_engine_param_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) ();

    logic             go;
    logic             seed_val;
    logic [WIDTH-1:0] seed;
    logic [CNT_W-1:0] nshift;
    logic             busy;
    logic             done_val;
    logic             done_rdy;
    logic [WIDTH-1:0] rand_out;

    modport master (
        output go,
        output seed_val,
        output seed,
        output nshift,
        output done_rdy,
        input  busy,
        input  done_val,
        input  rand_out
    );

    modport slave (
        input  go,
        input  seed_val,
        input  seed,
        input  nshift,
        input  done_rdy,
        output busy,
        output done_val,
        output rand_out
    );

endinterface

// File: rtl/lfsr_engine_param.sv
// Parametrised LFSR engine: per-request shift count, runtime seed, val/rdy result.
// Ports: clk, rst (sync, active low), bus (slave side of lfsr_engine_param_if).
module lfsr_engine_param #(
    parameter int unsigned      WIDTH      = 8,
    parameter logic [WIDTH-1:0] TAPS       = WIDTH'(8'hB8),
    parameter int unsigned      MODE       = 0,
    parameter int unsigned      CNT_W      = 8,
    parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(1)
) (
    input  logic               clk,
    input  logic               rst,
    lfsr_engine_param_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] seed_safe;

    // One LFSR step in the selected form.
    generate
        if (MODE == 0) begin : g_fib
            logic fb;
            assign fb       = ^(lfsr_q & TAPS);
            assign step_val = {lfsr_q[WIDTH-2:0], fb};
        end else begin : g_gal
            logic [WIDTH-1:0] shl;
            assign shl      = {lfsr_q[WIDTH-2:0], 1'b0};
            assign step_val = lfsr_q[WIDTH-1] ? (shl ^ TAPS) : shl;
        end
    endgenerate

    // A zero seed would lock the register at zero forever.
    assign seed_safe = (bus.seed == '0) ? WIDTH'(1) : bus.seed;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            lfsr_q  <= RESET_SEED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.seed_val) begin
                    lfsr_d = seed_safe;
                end
                if (bus.go) begin
                    cnt_d   = bus.nshift;
                    state_d = (bus.nshift == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                lfsr_d = step_val;
                cnt_d  = cnt_q - CNT_W'(1);
                // Leaving at 1 means the counter never wraps.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.done_rdy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done_val = (state_q == DONE);
    assign bus.rand_out = lfsr_q;

endmodule
